// File: rtl/sha256_round_engine.sv
// Iterative SHA-256 compression: one round per clock over a 16-word rolling message window.
// Accepts block + chaining state on a valid/ready handshake and returns state + compressed state.
module sha256_round_engine (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] block_in,
  input  logic [255:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest_out,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} state_e;

  localparam logic [31:0] RoundK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [31:0] choice(input logic [31:0] e, input logic [31:0] f,
                                         input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] majority(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  state_e        r_state;
  state_e        w_state_next;
  logic [5:0]    r_cnt;
  logic [31:0]   r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
  logic [31:0]   r_hash [8];
  logic [31:0]   r_win  [16];
  logic [255:0]  r_digest;

  logic [31:0]   w_t1;
  logic [31:0]   w_t2;
  logic [31:0]   w_sched;
  logic [31:0]   w_work [8];

  // W_t is always the head of the window; the tail is refilled with W_{t+16}.
  assign w_sched = small_sigma1(r_win[14]) + r_win[9] + small_sigma0(r_win[1]) + r_win[0];
  assign w_t1    = r_h + big_sigma1(r_e) + choice(r_e, r_f, r_g) + RoundK[r_cnt] + r_win[0];
  assign w_t2    = big_sigma0(r_a) + majority(r_a, r_b, r_c);
  assign w_work  = '{r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (in_valid) w_state_next = StRound;
      StRound: if (r_cnt == 6'd63) w_state_next = StFinal;
      StFinal: w_state_next = StDone;
      StDone:  if (out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_d      <= '0;
      r_e      <= '0;
      r_f      <= '0;
      r_g      <= '0;
      r_h      <= '0;
      r_digest <= '0;
      for (int i = 0; i < 8; i++) r_hash[i] <= '0;
      for (int i = 0; i < 16; i++) r_win[i] <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_cnt <= '0;
            r_a   <= state_in[255:224];
            r_b   <= state_in[223:192];
            r_c   <= state_in[191:160];
            r_d   <= state_in[159:128];
            r_e   <= state_in[127:96];
            r_f   <= state_in[95:64];
            r_g   <= state_in[63:32];
            r_h   <= state_in[31:0];
            for (int i = 0; i < 8; i++) r_hash[i] <= state_in[255-32*i -: 32];
            for (int i = 0; i < 16; i++) r_win[i] <= block_in[511-32*i -: 32];
          end
        end
        StRound: begin
          r_h <= r_g;
          r_g <= r_f;
          r_f <= r_e;
          r_e <= r_d + w_t1;
          r_d <= r_c;
          r_c <= r_b;
          r_b <= r_a;
          r_a <= w_t1 + w_t2;
          for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
          r_win[15] <= w_sched;
          r_cnt     <= r_cnt + 6'd1;
        end
        StFinal: begin
          for (int i = 0; i < 8; i++) r_digest[255-32*i -: 32] <= r_hash[i] + w_work[i];
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == StIdle);
  assign out_valid  = (r_state == StDone);
  assign busy       = (r_state == StRound) || (r_state == StFinal);
  assign digest_out = r_digest;

endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed bench for sha256_round_engine using published SHA-256 test vectors.
module tb_sha256_round_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] block_in;
  logic [255:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] digest_out;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [255:0] Iv =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] DigAbc =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DigEmpty =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] DigTwo =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [511:0] BlkAbc   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BlkEmpty = {32'h80000000, 480'h0};
  localparam logic [511:0] BlkTwo1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BlkTwo2  = {448'h0, 64'h1c0};

  sha256_round_engine dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .block_in   (block_in),
    .state_in   (state_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .digest_out (digest_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Waits for out_valid, returning the number of edges seen (capped at 200).
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_job(input string tag, input logic [511:0] blk, input logic [255:0] st,
                         input bit scramble, input bit chk_dig, input logic [255:0] exp,
                         output logic [255:0] dig);
    int lat;
    check_eq({tag, " ready"}, {in_ready, busy, out_valid}, 3'b100);
    block_in = blk;
    state_in = st;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (scramble) begin
      for (int i = 0; i < 16; i++) block_in[32*i +: 32] = $urandom();
      for (int i = 0; i < 8; i++) state_in[32*i +: 32] = $urandom();
    end
    check_eq({tag, " busy"}, {in_ready, busy}, 2'b01);
    wait_out(lat);
    check_eq({tag, " latency"}, lat, 65);
    dig = digest_out;
    if (chk_dig) check_eq({tag, " digest"}, digest_out, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, " handoff"}, {in_ready, out_valid, busy}, 3'b100);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] dig;
    logic [255:0] mid;
    bit           ok;
    int           lat;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    block_in  = '0;
    state_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset flags", {in_ready, out_valid, busy}, 3'b100);
    check_eq("reset digest", digest_out, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_job("abc", BlkAbc, Iv, 1'b0, 1'b1, DigAbc, dig);
    run_job("empty", BlkEmpty, Iv, 1'b0, 1'b1, DigEmpty, dig);

    run_job("two blk1", BlkTwo1, Iv, 1'b0, 1'b0, '0, mid);
    run_job("two blk2", BlkTwo2, mid, 1'b0, 1'b1, DigTwo, dig);

    run_job("scramble", BlkAbc, Iv, 1'b1, 1'b1, DigAbc, dig);

    // Backpressure: hold the digest while a competing job is offered.
    block_in = BlkAbc;
    state_in = Iv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    check_eq("bp latency", lat, 65);
    check_eq("bp digest", digest_out, DigAbc);
    block_in = BlkEmpty;
    state_in = Iv;
    in_valid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (digest_out !== DigAbc || in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b0)
        ok = 1'b0;
    end
    check_eq("bp hold", ok, 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("bp handoff", {in_ready, out_valid, busy}, 3'b100);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("bp accept", {in_ready, busy}, 2'b01);
    wait_out(lat);
    check_eq("bp2 latency", lat, 65);
    check_eq("bp2 digest", digest_out, DigEmpty);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Asynchronous reset during round 30.
    block_in = BlkEmpty;
    state_in = Iv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("mid rst flags", {in_ready, out_valid, busy}, 3'b100);
    check_eq("mid rst digest", digest_out, '0);
    #2;
    rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    check_eq("mid rst quiet", ok, 1'b1);
    run_job("post rst", BlkAbc, Iv, 1'b0, 1'b1, DigAbc, dig);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
